// File: rtl/snn_top.sv
// rtl/snn_top.sv - 16-neuron LIF spiking core with show-ahead spike event FIFO
//
// snn_event_fifo: spike address queue
//   clock, reset_n            clock, asynchronous active-low reset
//   s_tvalid, s_tdata         push strobe and address
//   m_tready                  pop strobe (ignored when empty)
//   m_tvalid, m_tdata         non-empty flag and head entry (0 when empty)
//
// snn_top: neuron array plus event FIFO
//   clock                     system clock, rising edge
//   reset_n                   asynchronous active-low reset
//   snn_ren                   host pop strobe
//   snn_event                 high while the event FIFO is non-empty
//   neuron_addr_out           address of the oldest pending spike (0 when empty)

module snn_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         s_tvalid,
    input  logic [W-1:0] s_tdata,
    input  logic         m_tready,
    output logic         m_tvalid,
    output logic [W-1:0] m_tdata
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = m_tready && !empty;
    // A pop in the same cycle frees a slot, so a push into a full queue
    // is accepted only when the head leaves at the same edge.
    assign do_push = s_tvalid && (!full || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever the queue is empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    assign m_tvalid = !empty;
    assign m_tdata  = empty ? '0 : mem[rd_ptr];
endmodule

module snn_top #(
    parameter int V_WIDTH    = 16,
    parameter int THRESHOLD  = 256,
    parameter int LEAK_SHIFT = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       snn_ren,
    output logic       snn_event,
    output logic [3:0] neuron_addr_out
);
    localparam int N = 16;

    logic [V_WIDTH-1:0] v_mem [N];
    logic [3:0]         ptr;
    logic [V_WIDTH-1:0] v_cur;
    logic [V_WIDTH-1:0] leak;
    logic [V_WIDTH-1:0] v_leaked;
    logic [V_WIDTH:0]   bias;
    logic [V_WIDTH:0]   sum;
    logic [V_WIDTH-1:0] v_next;
    logic               spike;

    always_comb begin
        v_cur    = v_mem[ptr];
        // A zero shift would otherwise subtract the whole potential.
        leak     = (LEAK_SHIFT == 0) ? '0 : (v_cur >> LEAK_SHIFT);
        v_leaked = v_cur - leak;
        // Neuron i carries a hard-wired bias of i+1.
        bias     = (V_WIDTH+1)'(ptr) + (V_WIDTH+1)'(1);
        sum      = {1'b0, v_leaked} + bias;
        v_next   = sum[V_WIDTH] ? '1 : sum[V_WIDTH-1:0];
        spike    = (32'(v_next) >= THRESHOLD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
            for (int i = 0; i < N; i++) begin
                v_mem[i] <= '0;
            end
        end else begin
            ptr        <= ptr + 4'd1;
            // Firing discards any excess above threshold, even if the
            // event itself is dropped by a full queue.
            v_mem[ptr] <= spike ? '0 : v_next;
        end
    end

    snn_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (4)
    ) u_event_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .s_tvalid (spike),
        .s_tdata  (ptr),
        .m_tready (snn_ren),
        .m_tvalid (snn_event),
        .m_tdata  (neuron_addr_out)
    );
endmodule

// File: tb/tb_snn_top.sv
// tb/tb_snn_top.sv - self-checking bench for snn_top against a queue-based reference model
module tb_snn_top;
    logic       clock = 1'b0;
    logic       rst0;
    logic       rst6;
    logic       ren0;
    logic       ren6;
    logic       ev0;
    logic       ev6;
    logic [3:0] a0;
    logic [3:0] a6;

    always #5 clock = ~clock;

    snn_top #(.LEAK_SHIFT(0)) dut0 (
        .clock           (clock),
        .reset_n         (rst0),
        .snn_ren         (ren0),
        .snn_event       (ev0),
        .neuron_addr_out (a0)
    );

    snn_top dut6 (
        .clock           (clock),
        .reset_n         (rst6),
        .snn_ren         (ren6),
        .snn_event       (ev6),
        .neuron_addr_out (a6)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: potentials as plain integers, FIFO as a queue.
    int mv [16];
    int mptr;
    int mls;
    int q [$];

    int exp_heads [8]  = '{13, 12, 11, 10, 9, 8, 13, 0};
    int exp_order [10] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 15};
    int exp_cyc   [10] = '{256, 287, 302, 317, 348, 379, 410, 457, 504, 512};
    int pop_addr [$];
    int pop_cyc  [$];
    int cnt [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int ls);
        for (int i = 0; i < 16; i++) mv[i] = 0;
        mptr = 0;
        mls  = ls;
        q.delete();
    endtask

    task automatic model_edge(input bit ren);
        int  vn;
        bit  spk;
        bit  pop;
        pop = ren && (q.size() > 0);
        vn  = mv[mptr] - ((mls == 0) ? 0 : (mv[mptr] >> mls)) + mptr + 1;
        if (vn > 65535) vn = 65535;
        spk = (vn >= 256);
        mv[mptr] = spk ? 0 : vn;
        if (pop) void'(q.pop_front());
        if (spk && q.size() < 8) q.push_back(mptr);
        mptr = (mptr + 1) % 16;
    endtask

    task automatic step(input bit use6, input bit ren);
        int exp_addr;
        if (use6) ren6 = ren;
        else      ren0 = ren;
        @(posedge clock);
        model_edge(ren);
        #1;
        exp_addr = 0;
        if (q.size() != 0) exp_addr = q[0];
        chk("event", use6 ? ev6 : ev0, (q.size() != 0));
        chk("addr", use6 ? a6 : a0, exp_addr);
    endtask

    initial begin
        int  maxo;
        bit  r;
        rst0 = 1'b0;
        rst6 = 1'b0;
        ren0 = 1'b0;
        ren6 = 1'b0;
        for (int i = 0; i < 16; i++) cnt[i] = 0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_event0", ev0, 0);
        chk("reset_addr0", a0, 0);
        chk("reset_event6", ev6, 0);
        chk("reset_addr6", a6, 0);

        // No leak: first spike, fill to full, pop while pushing on full, drain.
        rst0 = 1'b1;
        model_reset(0);
        for (int c = 0; c < 628; c++) begin
            r = (c == 605) || (c >= 620);
            step(1'b0, r);
            if (c == 254) chk("quiet_254", ev0, 0);
            if (c == 255) begin
                chk("first_event", ev0, 1);
                chk("first_addr", a0, 15);
            end
            if (c == 604) chk("full_head", a0, 15);
            if (c == 605) chk("pushpop_head", a0, 14);
            if (c >= 620) chk("drain_head", a0, exp_heads[c-620]);
            if (c == 627) chk("drain_empty", ev0, 0);
        end

        // No leak: pop each event as soon as it appears.
        rst0 = 1'b0;
        ren0 = 1'b0;
        #1;
        chk("async_reset_event0", ev0, 0);
        repeat (3) @(posedge clock);
        #1;
        rst0 = 1'b1;
        model_reset(0);
        for (int c = 0; c < 520; c++) begin
            r = ev0;
            if (r) begin
                pop_addr.push_back(int'(a0));
                pop_cyc.push_back(c);
            end
            step(1'b0, r);
        end
        chk("order_count", pop_addr.size() >= 10, 1);
        for (int i = 0; i < 10; i++) begin
            if (i < pop_addr.size()) begin
                chk("order_addr", pop_addr[i], exp_order[i]);
                chk("order_cycle", pop_cyc[i], exp_cyc[i]);
            end
        end

        // Default leak: random draining, then a quiet stretch and mid-run reset.
        rst0 = 1'b0;
        ren0 = 1'b0;
        rst6 = 1'b1;
        model_reset(6);
        for (int c = 0; c < 20000; c++) begin
            r = (c < 19600) ? ($urandom_range(0, 3) != 0) : 1'b0;
            if (r && ev6) cnt[a6] = cnt[a6] + 1;
            step(1'b1, r);
        end
        chk("leak_addr0", cnt[0], 0);
        chk("leak_addr1", cnt[1], 0);
        chk("leak_addr2", cnt[2], 0);
        maxo = 0;
        for (int i = 3; i < 15; i++) if (cnt[i] > maxo) maxo = cnt[i];
        chk("leak_15_most", cnt[15] > maxo, 1);
        chk("pre_reset_event", ev6, 1);
        rst6 = 1'b0;
        #1;
        chk("midrun_reset_event", ev6, 0);
        chk("midrun_reset_addr", a6, 0);
        @(posedge clock);
        #1;
        chk("held_reset_event", ev6, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
